bus_timer: RTL and testbench

Memory-mapped 16-bit countdown timer that sits on the 65C02 CPU bus as a responder. It decodes the CPU address bus and accepts register writes on WE. It returns registered read data one cycle after the address, matching the synchronous-RAM timing the CPU expects on its data input. It drives the CPU IRQ line when the timer expires.

---
 rtl/bus_timer_if.sv | 19 +
 rtl/bus_timer.sv | 135 +++++++++++++
 tb/tb_bus_timer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/bus_timer_if.sv
// rtl/bus_timer_if.sv - CPU bus bundle between the 65C02 and the bus_timer responder
interface bus_timer_if;
    logic [15:0] AD;
    logic [7:0]  DI;
    logic        WE;
    logic        RDY;
    logic [7:0]  DO;
    logic        IRQ;

    modport master (
        output AD, DI, WE, RDY,
        input  DO, IRQ
    );

    modport slave (
        input  AD, DI, WE, RDY,
        output DO, IRQ
    );
endinterface

// File: rtl/bus_timer.sv
// rtl/bus_timer.sv - memory-mapped 16-bit countdown timer with IRQ; optional TIMER_LATCH_EN shadow for coherent CNTL/CNTH reads
module bus_timer #(
    parameter logic [15:0] BASE = 16'hFE00
) (
    input  logic       clk,
    input  logic       rst,
    bus_timer_if.slave bus
);

    logic [2:0]  reg_addr;
    logic        sel;
    logic        wr;
    logic        rd;

    logic [15:0] counter;
    logic [15:0] reload;
    logic [7:0]  pre;
    logic [7:0]  presc;
    logic        en;
    logic        auto_rl;
    logic        ie;
    logic        tf;

    logic        tick;
    logic        relh_wr;
    logic        expire;
    logic [7:0]  cnth;
    logic [7:0]  rdata;

    assign reg_addr = bus.AD[2:0];
    assign sel      = (bus.AD[15:3] == BASE[15:3]) && bus.RDY;
    assign wr       = sel && bus.WE;
    assign rd       = sel && !bus.WE;

    // A RELH load restarts the count, so any tick landing on the same edge is dropped
    assign tick     = en && (presc == 8'd0);
    assign relh_wr  = wr && (reg_addr == 3'd3);
    assign expire   = tick && !relh_wr && (counter == 16'd0);

`ifdef TIMER_LATCH_EN
    logic [7:0] shadow;

    // Capture the high byte when CNTL is read so the following CNTH read is coherent
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= 8'd0;
        end else if (rd && (reg_addr == 3'd0)) begin
            shadow <= counter[15:8];
        end
    end

    assign cnth = shadow;
`else
    assign cnth = counter[15:8];
`endif

    // Register read mux; unused bits and the spare slot read as zero
    always_comb begin
        rdata = 8'h00;
        case (reg_addr)
            3'd0:    rdata = counter[7:0];
            3'd1:    rdata = cnth;
            3'd2:    rdata = reload[7:0];
            3'd3:    rdata = reload[15:8];
            3'd4:    rdata = {5'b00000, ie, auto_rl, en};
            3'd5:    rdata = pre;
            3'd6:    rdata = {7'b0000000, tf};
            default: rdata = 8'h00;
        endcase
    end

    // Registered bus outputs: DO is zero after any non-read so it can be OR-muxed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.DO  <= 8'h00;
            bus.IRQ <= 1'b0;
        end else begin
            bus.DO  <= rd ? rdata : 8'h00;
            bus.IRQ <= tf && ie;
        end
    end

    // Timer state: register writes, prescaler, counter and expiry flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter <= 16'd0;
            reload  <= 16'd0;
            pre     <= 8'd0;
            presc   <= 8'd0;
            en      <= 1'b0;
            auto_rl <= 1'b0;
            ie      <= 1'b0;
            tf      <= 1'b0;
        end else begin
            if (wr) begin
                case (reg_addr)
                    3'd2:    reload[7:0]        <= bus.DI;
                    3'd3:    reload[15:8]       <= bus.DI;
                    3'd4:    {ie, auto_rl, en}  <= bus.DI[2:0];
                    3'd5:    pre                <= bus.DI;
                    default: ;
                endcase
            end

            if (relh_wr) begin
                presc <= pre;
            end else if (en) begin
                presc <= (presc == 8'd0) ? pre : presc - 8'd1;
            end

            if (relh_wr) begin
                counter <= {bus.DI, reload[7:0]};
            end else if (tick) begin
                if (counter != 16'd0) begin
                    counter <= counter - 16'd1;
                end else if (auto_rl) begin
                    counter <= reload;
                end
            end

            // One-shot expiry disables the timer even if CTRL is written on the same edge
            if (expire && !auto_rl) begin
                en <= 1'b0;
            end

            // Setting TF has priority over a simultaneous software clear
            if (expire) begin
                tf <= 1'b1;
            end else if (wr && (reg_addr == 3'd6) && bus.DI[0]) begin
                tf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bus_timer.sv
// tb/tb_bus_timer.sv - self-checking bench for bus_timer: directed steps plus random bus traffic against a reference model
module tb_bus_timer;

    localparam logic [15:0] BASE = 16'hFE00;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    bus_timer_if bus ();

    bus_timer #(.BASE(BASE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state, kept as plain integers
    int m_counter, m_reload, m_pre, m_clocks_left, m_shadow;
    bit m_en, m_auto, m_ie, m_tf;
    int m_do;
    bit m_irq;

    task automatic check(input string tag, input int obs, input int exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_counter = 0; m_reload = 0; m_pre = 0; m_clocks_left = 0; m_shadow = 0;
        m_en = 0; m_auto = 0; m_ie = 0; m_tf = 0; m_do = 0; m_irq = 0;
    endtask

    function automatic int model_read(input int a);
        case (a)
            0: return m_counter % 256;
`ifdef TIMER_LATCH_EN
            1: return m_shadow;
`else
            1: return m_counter / 256;
`endif
            2: return m_reload % 256;
            3: return m_reload / 256;
            4: return int'(m_en) + 2 * int'(m_auto) + 4 * int'(m_ie);
            5: return m_pre;
            6: return int'(m_tf);
            default: return 0;
        endcase
    endfunction

    // One clock edge of the timer, from the rules: reads see the old state, writes land at the edge
    task automatic model_edge(input logic [15:0] ad, input logic [7:0] di, input logic we, input logic rdy);
        int a;
        bit sel, w, r, tick, load, expired, was_auto;
        a        = int'(ad[2:0]);
        sel      = (ad[15:3] == BASE[15:3]) && rdy;
        w        = sel && we;
        r        = sel && !we;
        m_do     = r ? model_read(a) : 0;
        m_irq    = m_tf && m_ie;
        if (r && a == 0) m_shadow = m_counter / 256;
        tick     = m_en && (m_clocks_left == 0);
        load     = w && (a == 3);
        expired  = tick && !load && (m_counter == 0);
        was_auto = m_auto;

        if (load) m_counter = int'(di) * 256 + (m_reload % 256);
        else if (tick) begin
            if (m_counter > 0) m_counter = m_counter - 1;
            else if (was_auto) m_counter = m_reload;
        end

        if (load) m_clocks_left = m_pre;
        else if (m_en) m_clocks_left = (m_clocks_left == 0) ? m_pre : m_clocks_left - 1;

        if (expired) m_tf = 1;
        else if (w && a == 6 && di[0]) m_tf = 0;

        if (w) begin
            case (a)
                2: m_reload = (m_reload / 256) * 256 + int'(di);
                3: m_reload = int'(di) * 256 + (m_reload % 256);
                4: begin m_en = di[0]; m_auto = di[1]; m_ie = di[2]; end
                5: m_pre = int'(di);
                default: ;
            endcase
        end
        if (expired && !was_auto) m_en = 0;
    endtask

    // One bus cycle: drive, clock, update model, compare outputs on the falling edge
    task automatic cyc(input logic [15:0] ad, input logic [7:0] di, input logic we, input logic rdy);
        bus.AD = ad; bus.DI = di; bus.WE = we; bus.RDY = rdy;
        @(posedge clk);
        if (rst) model_reset();
        else model_edge(ad, di, we, rdy);
        @(negedge clk);
        check("model_do", int'(bus.DO), m_do);
        check("model_irq", int'(bus.IRQ), int'(m_irq));
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        cyc(BASE + 16'(a), d, 1'b1, 1'b1);
    endtask

    task automatic rd(input int a);
        cyc(BASE + 16'(a), 8'h00, 1'b0, 1'b1);
    endtask

    task automatic idle();
        cyc(16'h0000, 8'h00, 1'b0, 1'b1);
    endtask

    initial begin
        logic [15:0] ad;
        logic [7:0]  di;
        tests_run = 0;
        tests_failed = 0;
        model_reset();
        bus.AD = 16'h0; bus.DI = 8'h0; bus.WE = 1'b0; bus.RDY = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        // Reset held with bus activity
        wr(3, 8'h55);
        rd(4);
        check("reset_do", int'(bus.DO), 0);
        check("reset_irq", int'(bus.IRQ), 0);
        rst = 1'b0;
        rd(4);
        check("post_reset_ctrl", int'(bus.DO), 8'h00);

        // Register access
        wr(2, 8'h34);
        wr(3, 8'h12);
        rd(2); check("rell", int'(bus.DO), 8'h34);
        rd(3); check("relh", int'(bus.DO), 8'h12);
        rd(0); check("cntl", int'(bus.DO), 8'h34);
        rd(7); check("spare", int'(bus.DO), 8'h00);

        // One-shot expiry: 4 ticks of 3 clocks after the CTRL write
        wr(5, 8'h02);
        wr(2, 8'h03);
        wr(3, 8'h00);
        wr(4, 8'h05);
        repeat (11) idle();
        rd(6);
        check("oneshot_tf_early", int'(bus.DO), 0);
        check("oneshot_irq_early", int'(bus.IRQ), 0);
        rd(6);
        check("oneshot_tf", int'(bus.DO), 1);
        check("oneshot_irq", int'(bus.IRQ), 1);
        rd(4); check("oneshot_ctrl", int'(bus.DO), 8'h04);
        wr(6, 8'h01);
        check("irq_hold_after_clear", int'(bus.IRQ), 1);
        idle();
        check("irq_drop", int'(bus.IRQ), 0);

        // Auto-reload every 2 clocks, with a clear colliding with an expiry
        wr(4, 8'h00);
        wr(5, 8'h00);
        wr(2, 8'h01);
        wr(3, 8'h00);
        wr(4, 8'h03);
        idle();
        idle();
        wr(6, 8'h01);
        wr(6, 8'h01);
        rd(6); check("auto_set_wins", int'(bus.DO), 1);
        rd(6); check("auto_tf_held", int'(bus.DO), 1);
        wr(6, 8'h01);
        rd(6); check("auto_tf_cleared", int'(bus.DO), 0);
        rd(6); check("auto_tf_period", int'(bus.DO), 1);

        // RDY low blocks the write and returns zero
        wr(4, 8'h00);
        cyc(BASE + 16'd6, 8'h01, 1'b1, 1'b0);
        check("rdy_low_do", int'(bus.DO), 0);
        rd(6); check("rdy_low_tf", int'(bus.DO), 1);

        // Coherent counter read across a decrement
        wr(5, 8'h00);
        wr(2, 8'h00);
        wr(4, 8'h01);
        wr(3, 8'h01);
        rd(0); check("latch_cntl", int'(bus.DO), 8'h00);
        rd(1);
`ifdef TIMER_LATCH_EN
        check("latch_cnth", int'(bus.DO), 8'h01);
`else
        check("live_cnth", int'(bus.DO), 8'h00);
`endif

        // Asynchronous reset mid-operation
        wr(4, 8'h04);
        idle();
        check("irq_before_rst", int'(bus.IRQ), 1);
        rd(6);
        check("tf_before_rst", int'(bus.DO), 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_do", int'(bus.DO), 0);
        check("async_rst_irq", int'(bus.IRQ), 0);
        model_reset();
        idle();
        idle();
        rst = 1'b0;
        rd(6); check("after_rst_tf", int'(bus.DO), 0);
        rd(2); check("after_rst_rell", int'(bus.DO), 0);

        // Random bus traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) < 8) ad = {BASE[15:3], 3'($urandom_range(0, 7))};
            else ad = 16'($urandom);
            di = 8'($urandom);
            if (ad[2:0] == 3'd3 || ad[2:0] == 3'd5) di = 8'($urandom_range(0, 3));
            if (ad[2:0] == 3'd4 && $urandom_range(0, 3) != 0) di[0] = 1'b1;
            cyc(ad, di, 1'($urandom_range(0, 1)), $urandom_range(0, 7) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
